// File: rtl/seq_3_to_8_decoder.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready and drives its one-hot
// line for HOLD cycles, with a one-entry pending buffer for back-to-back codes.
module seq_3_to_8_decoder #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    if (HOLD < 1 || HOLD > 255 || CNT_W < 1 || CNT_W > 30 || (2 ** CNT_W) <= HOLD) begin : g_bad_param
        $error("seq_3_to_8_decoder: illegal HOLD/CNT_W combination");
    end

    // Code 0 maps to the MSB so an 8-to-3 priority encoder inverts it.
    function automatic logic [7:0] one_hot(input logic [2:0] code);
        one_hot = 8'h80 >> code;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       active_code_q, active_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [2:0]       pend_code_q, pend_code_d;
    logic [7:0]       out_q, out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             xfer_s;
    logic             last_s;

    assign in_ready = !pend_valid_q;
    assign out      = out_q;
    assign done     = done_q;
    assign busy     = busy_q;

    // Next-state logic; outputs are precomputed from the next state so they come straight off flops.
    always_comb begin
        state_d       = state_q;
        active_code_d = active_code_q;
        cnt_d         = cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_code_d   = pend_code_q;
        xfer_s        = in_valid && !pend_valid_q;
        last_s        = (state_q == DRIVE) && (cnt_q == CNT_ZERO);

        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    active_code_d = in_code;
                    cnt_d         = RELOAD;
                    state_d       = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (!last_s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (xfer_s) begin
                        pend_valid_d = 1'b1;
                        pend_code_d  = in_code;
                    end else begin
                        pend_valid_d = pend_valid_q;
                    end
                end else if (pend_valid_q) begin
                    // Pending code takes over with no idle gap; in_ready is low so no transfer can collide.
                    active_code_d = pend_code_q;
                    pend_valid_d  = 1'b0;
                    cnt_d         = RELOAD;
                end else if (xfer_s) begin
                    active_code_d = in_code;
                    cnt_d         = RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DRIVE) begin
            out_d  = one_hot(active_code_d);
            done_d = (cnt_d == CNT_ZERO);
        end else begin
            out_d  = 8'h00;
            done_d = 1'b0;
        end
        busy_d = (state_d == DRIVE) || pend_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            active_code_q <= 3'b000;
            cnt_q         <= CNT_ZERO;
            pend_valid_q  <= 1'b0;
            pend_code_q   <= 3'b000;
            out_q         <= 8'h00;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_code_q <= active_code_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_code_q   <= pend_code_d;
            out_q         <= out_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_seq_3_to_8_decoder.sv
// Bench for seq_3_to_8_decoder: three instances (HOLD=4,3,1) checked every cycle
// against a window-schedule model, plus directed literal expectations.
module tb_seq_3_to_8_decoder;

    logic       clk;
    logic       rst_n;
    logic       vin   [3];
    logic [2:0] vcode [3];
    logic       rdy   [3];
    logic [7:0] dout  [3];
    logic       bsy   [3];
    logic       dn    [3];

    int nerr = 0;
    int nchk = 0;

    seq_3_to_8_decoder #(.HOLD(4), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
        .in_code(vcode[0]), .out(dout[0]), .busy(bsy[0]), .done(dn[0]));
    seq_3_to_8_decoder #(.HOLD(3), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
        .in_code(vcode[1]), .out(dout[1]), .busy(bsy[1]), .done(dn[1]));
    seq_3_to_8_decoder #(.HOLD(1), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(rdy[2]),
        .in_code(vcode[2]), .out(dout[2]), .busy(bsy[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hold_of(input int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    // Model: each accepted code owns a window of cycles [s, e] on its instance.
    typedef struct {
        int         inst;
        int         s;
        int         e;
        logic [2:0] code;
    } win_t;

    win_t wins[$];
    int   cyc = 0;
    int   last_end[3] = '{-10, -10, -10};

    function automatic bit m_ready(input int i, input int c);
        foreach (wins[k]) if (wins[k].inst == i && wins[k].s > c) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_out(input int i, input int c);
        foreach (wins[k])
            if (wins[k].inst == i && wins[k].s <= c && c <= wins[k].e)
                return 8'h80 >> wins[k].code;
        return 8'h00;
    endfunction

    function automatic bit m_done(input int i, input int c);
        foreach (wins[k]) if (wins[k].inst == i && wins[k].e == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input int i, input int c);
        foreach (wins[k]) if (wins[k].inst == i && wins[k].e >= c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int enc8to3(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) if (v[b]) return 7 - b;
        return -1;
    endfunction

    // Model update: a transfer at the edge ending cycle cyc starts its window
    // at cyc+1, or right after the previous window if that is later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wins.delete();
            for (int i = 0; i < 3; i++) last_end[i] = -10;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vin[i] && m_ready(i, cyc)) begin
                    win_t w;
                    w.inst = i;
                    w.s    = (cyc + 1 > last_end[i] + 1) ? cyc + 1 : last_end[i] + 1;
                    w.e    = w.s + hold_of(i) - 1;
                    w.code = vcode[i];
                    wins.push_back(w);
                    last_end[i] = w.e;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d out", i),      int'(dout[i]), int'(m_out(i, cyc)));
            chk($sformatf("u%0d done", i),     int'(dn[i]),   int'(m_done(i, cyc)));
            chk($sformatf("u%0d busy", i),     int'(bsy[i]),  int'(m_busy(i, cyc)));
            chk($sformatf("u%0d in_ready", i), int'(rdy[i]),  int'(m_ready(i, cyc)));
        end
    end

    logic [7:0] lout[$];
    bit         lrdy[$];
    bit         ldn[$];
    bit         rec   = 1'b0;
    int         rec_i = 0;

    always @(negedge clk) begin
        if (rec) begin
            lout.push_back(dout[rec_i]);
            lrdy.push_back(rdy[rec_i]);
            ldn.push_back(dn[rec_i]);
        end
    end

    task automatic start_rec(input int i);
        lout.delete();
        lrdy.delete();
        ldn.delete();
        rec_i = i;
        rec   = 1'b1;
    endtask

    function automatic int first_nz();
        foreach (lout[k]) if (lout[k] != 8'h00) return k;
        return -1;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge, valid still high.
    task automatic send(input int i, input logic [2:0] c);
        bit r;
        int n;
        vin[i]   = 1'b1;
        vcode[i] = c;
        n = 0;
        do begin
            @(negedge clk);
            r = rdy[i];
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        chk($sformatf("u%0d accept code %0d", i, c), int'(r), 1);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] lit[8];
    int f;
    int nz;

    initial begin
        lit = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i]   = 1'b0;
            vcode[i] = 3'b000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out",      int'(dout[0]), 8'h00);
        chk("reset busy",     int'(bsy[0]),  0);
        chk("reset done",     int'(dn[0]),   0);
        chk("reset in_ready", int'(rdy[0]),  1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single code 3'b010 with HOLD=4.
        send(0, 3'b010);
        vin[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("single out c%0d", k),  int'(dout[0]), 8'h20);
            chk($sformatf("single done c%0d", k), int'(dn[0]),   (k == 4) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("single out after", int'(dout[0]), 8'h00);
        chk("single busy after", int'(bsy[0]), 0);
        gap(2);

        // All eight codes with idle gaps, round-tripped through an 8-to-3 encoder.
        for (int c = 0; c < 8; c++) begin
            send(0, 3'(c));
            vin[0] = 1'b0;
            @(negedge clk);
            chk($sformatf("code %0d out", c), int'(dout[0]), int'(lit[c]));
            chk($sformatf("code %0d roundtrip", c), enc8to3(dout[0]), c);
            gap(5);
        end

        // Back-to-back 000, 111, 101 with valid held high.
        start_rec(0);
        send(0, 3'b000);
        send(0, 3'b111);
        send(0, 3'b101);
        vin[0] = 1'b0;
        gap(16);
        rec = 1'b0;
        f = first_nz();
        chk("b2b started", int'(f >= 0), 1);
        if (f >= 0) begin
            for (int k = 0; k < 12; k++)
                chk($sformatf("b2b out c%0d", k), int'(lout[f + k]),
                    (k < 4) ? 8'h80 : (k < 8) ? 8'h01 : 8'h04);
            chk("b2b out end",  int'(lout[f + 12]), 8'h00);
            chk("b2b rdy c1",   int'(lrdy[f + 1]), 0);
            chk("b2b rdy c3",   int'(lrdy[f + 3]), 0);
            chk("b2b rdy c7",   int'(lrdy[f + 7]), 0);
            chk("b2b rdy c8",   int'(lrdy[f + 8]), 1);
        end

        // HOLD=3: direct load of 3'b100 on the done cycle of 3'b001.
        start_rec(1);
        send(1, 3'b001);
        vin[1] = 1'b0;
        gap(2);
        send(1, 3'b100);
        vin[1] = 1'b0;
        gap(6);
        rec = 1'b0;
        f = first_nz();
        chk("direct started", int'(f >= 0), 1);
        if (f >= 0) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("direct out c%0d", k), int'(lout[f + k]), (k < 3) ? 8'h40 : 8'h08);
                chk($sformatf("direct rdy c%0d", k), int'(lrdy[f + k]), 1);
            end
            chk("direct done c2", int'(ldn[f + 2]), 1);
            chk("direct out end", int'(lout[f + 6]), 8'h00);
        end

        // HOLD=1: one code per cycle.
        start_rec(2);
        send(2, 3'b011);
        send(2, 3'b110);
        send(2, 3'b001);
        vin[2] = 1'b0;
        gap(4);
        rec = 1'b0;
        f = first_nz();
        chk("hold1 started", int'(f >= 1), 1);
        if (f >= 1) begin
            chk("hold1 out c0", int'(lout[f]),     8'h10);
            chk("hold1 out c1", int'(lout[f + 1]), 8'h02);
            chk("hold1 out c2", int'(lout[f + 2]), 8'h40);
            chk("hold1 out end", int'(lout[f + 3]), 8'h00);
            for (int k = 0; k < 3; k++)
                chk($sformatf("hold1 done c%0d", k), int'(ldn[f + k]), 1);
            for (int k = -1; k < 3; k++)
                chk($sformatf("hold1 rdy c%0d", k), int'(lrdy[f + k]), 1);
        end

        // Asynchronous reset in cycle 2 of a 3'b000 hold with 3'b111 pending.
        send(0, 3'b000);
        send(0, 3'b111);
        vin[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out",      int'(dout[0]), 8'h00);
        chk("async rst in_ready", int'(rdy[0]),  1);
        chk("async rst busy",     int'(bsy[0]),  0);
        chk("async rst done",     int'(dn[0]),   0);
        #1 rst_n = 1'b1;
        start_rec(0);
        gap(12);
        rec = 1'b0;
        nz = 0;
        foreach (lout[k]) if (lout[k] != 8'h00) nz++;
        chk("after rst no reappear", nz, 0);

        // Fresh transfer after reset still works.
        send(0, 3'b110);
        vin[0] = 1'b0;
        @(negedge clk);
        chk("post rst out", int'(dout[0]), 8'h02);
        gap(6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
